// File: rtl/activation_cache.sv
// Circular cache of past activation vectors producing dilated causal taps x[t-3d], x[t-2d], x[t-d], x[t].
// Optional ACTIVATION_CACHE_WARMUP_EN holds out_v low until the receptive field is full.
module activation_cache #(
  parameter int unsigned W        = 16,
  parameter int unsigned D        = 16,
  parameter int unsigned DILATION = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_v,
  input  logic [D*W-1:0] packed_in,
  output logic           in_ready,
  output logic [D*W-1:0] packed_a0,
  output logic [D*W-1:0] packed_a1,
  output logic [D*W-1:0] packed_a2,
  output logic [D*W-1:0] packed_a3,
  output logic           out_v
);

  localparam int unsigned DEPTH = 3 * DILATION + 1;
  localparam int unsigned DW    = D * W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_v_q, out_v_d;
  logic [DW-1:0]    a0_q, a0_d, a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic             accept_c;
  logic [DW-1:0]    tap1_c, tap2_c, tap3_c;

  // (ptr + DEPTH - off) mod DEPTH, kept non-negative in a 2*DEPTH-wide sum
  function automatic logic [PTR_W-1:0] tap_addr(input logic [PTR_W-1:0] ptr,
                                                input int unsigned off);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(DEPTH - off);
    if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
    return PTR_W'(sum);
  endfunction

  assign accept_c = in_v && in_ready_q;

  // Past taps with causal zero padding until enough samples exist
  always_comb begin
    tap1_c = (cnt_q < PTR_W'(DILATION))     ? '0 : mem_q[tap_addr(wr_ptr_q, DILATION)];
    tap2_c = (cnt_q < PTR_W'(2 * DILATION)) ? '0 : mem_q[tap_addr(wr_ptr_q, 2 * DILATION)];
    tap3_c = (cnt_q < PTR_W'(3 * DILATION)) ? '0 : mem_q[tap_addr(wr_ptr_q, 3 * DILATION)];
  end

  // Storage is deliberately not reset; cnt guards every read
  always_ff @(posedge clk) begin
    if (accept_c) mem_q[wr_ptr_q] <= packed_in;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    out_v_d    = out_v_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    case (state_q)
      IDLE, OUTPUT: begin
        if (in_v) begin
          a3_d       = packed_in;
          out_v_d    = 1'b0;
          in_ready_d = 1'b0;
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        a2_d       = tap1_c;
        a1_d       = tap2_c;
        a0_d       = tap3_c;
        wr_ptr_d   = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        cnt_d      = (cnt_q == LAST) ? cnt_q : cnt_q + PTR_W'(1);
        in_ready_d = 1'b1;
`ifdef ACTIVATION_CACHE_WARMUP_EN
        if (cnt_q == LAST) begin
          out_v_d = 1'b1;
          state_d = OUTPUT;
        end else begin
          out_v_d = 1'b0;
          state_d = IDLE;
        end
`else
        out_v_d    = 1'b1;
        state_d    = OUTPUT;
`endif
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        out_v_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      out_v_q    <= 1'b0;
      a0_q       <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      out_v_q    <= out_v_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_v     = out_v_q;
  assign packed_a0 = a0_q;
  assign packed_a1 = a1_q;
  assign packed_a2 = a2_q;
  assign packed_a3 = a3_q;

endmodule

// File: tb/tb_activation_cache.sv
// Bench for activation_cache: two instances (dilation 1 and 2) share one stimulus stream
// and are compared every cycle against a history-queue model of the causal taps.
module tb_activation_cache;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 16;
  localparam int unsigned VW = W * D;
`ifdef ACTIVATION_CACHE_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst;
  logic in_v;
  vec_t packed_in;
  logic rdy [2];
  logic ov  [2];
  vec_t tap [2][4];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    activation_cache #(.W(W), .D(D), .DILATION(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_v      (in_v),
      .packed_in (packed_in),
      .in_ready  (rdy[g]),
      .packed_a0 (tap[g][0]),
      .packed_a1 (tap[g][1]),
      .packed_a2 (tap[g][2]),
      .packed_a3 (tap[g][3]),
      .out_v     (ov[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: every accepted vector since reset ----------------
  vec_t hist [$];
  logic cap_pend = 1'b0;
  logic exp_rdy  = 1'b1;
  logic exp_ov  [2] = '{default: 1'b0};
  vec_t exp_tap [2][4] = '{default: '0};
  int   accepts = 0;

  function automatic vec_t tap_of(input int d, input int k);
    int t;
    t = hist.size() - 1;
    if (t >= k * d) return hist[t - k * d];
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      cap_pend <= 1'b0;
      exp_rdy  <= 1'b1;
      for (int g = 0; g < 2; g++) begin
        exp_ov[g] <= 1'b0;
        for (int k = 0; k < 4; k++) exp_tap[g][k] <= '0;
      end
    end else if (cap_pend) begin
      cap_pend <= 1'b0;
      exp_rdy  <= 1'b1;
      for (int g = 0; g < 2; g++) begin
        exp_tap[g][2] <= tap_of(g + 1, 1);
        exp_tap[g][1] <= tap_of(g + 1, 2);
        exp_tap[g][0] <= tap_of(g + 1, 3);
        exp_ov[g]     <= WARM ? (hist.size() >= 3 * (g + 1) + 1) : 1'b1;
      end
    end else if (in_v) begin
      hist.push_back(packed_in);
      cap_pend <= 1'b1;
      exp_rdy  <= 1'b0;
      accepts  <= accepts + 1;
      for (int g = 0; g < 2; g++) begin
        exp_ov[g]     <= 1'b0;
        exp_tap[g][3] <= packed_in;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("in_ready[d%0d]", g + 1), VW'(rdy[g]), VW'(exp_rdy));
      chk($sformatf("out_v[d%0d]", g + 1), VW'(ov[g]), VW'(exp_ov[g]));
      for (int k = 0; k < 4; k++)
        chk($sformatf("a%0d[d%0d]", k, g + 1), tap[g][k], exp_tap[g][k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic vec_t rep(input logic [15:0] e);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = e;
    return v;
  endfunction

  function automatic vec_t alt(input bit first_neg);
    vec_t v;
    for (int e = 0; e < 16; e++)
      v[VW-1-e*16 -: 16] = ((e % 2 == 0) == first_neg) ? 16'h8000 : 16'h7FFF;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    in_v      = 1'b1;
    packed_in = v;
    while (!rdy[0] && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("send_ready", VW'(rdy[0]), VW'(1));
    @(posedge clk);
    #1 in_v = 1'b0;
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    int a_before;
    rst       = 1'b1;
    in_v      = 1'b0;
    packed_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", VW'(rdy[0]), VW'(1));
    chk("rst_out_v", VW'(ov[0]), VW'(0));
    chk("rst_a3", tap[0][3], '0);
    chk("rst_a0_d2", tap[1][0], '0);
    #2 rst = 1'b0;

    // first vector after reset
    send(rep(16'h0100));
    @(negedge clk);
    chk("first_a3_early", tap[0][3], rep(16'h0100));
    chk("first_outv_low", VW'(ov[0]), VW'(0));
    @(negedge clk);
    chk("first_out_v", VW'(ov[0]), VW'(!WARM));
    chk("first_a3", tap[0][3], rep(16'h0100));
    chk("first_a2", tap[0][2], '0);
    chk("first_a1", tap[0][1], '0);
    chk("first_a0", tap[0][0], '0);

    // fill, steady state and wrap-around
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      send(rep(16'(n)));
      repeat (2) @(negedge clk);
      if (n >= 4) begin
        chk("wrap_a0", tap[0][0], rep(16'(n - 3)));
        chk("wrap_a3", tap[0][3], rep(16'(n)));
      end
    end
    chk("fill_a3", tap[1][3], rep(16'd10));
    chk("fill_a2", tap[1][2], rep(16'd8));
    chk("fill_a1", tap[1][1], rep(16'd6));
    chk("fill_a0", tap[1][0], rep(16'd4));
    chk("fill_out_v", VW'(ov[1]), VW'(1));

    // back-to-back in_v: one accept per two cycles
    a_before = accepts;
    @(negedge clk);
    in_v = 1'b1;
    repeat (40) begin
      packed_in = rnd();
      @(negedge clk);
    end
    in_v = 1'b0;
    chk("b2b_accepts", VW'(accepts - a_before), VW'(20));

    // reset while in CAPTURE
    do_reset();
    for (int n = 1; n <= 5; n++) send(rnd());
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_v", VW'(ov[0]), VW'(0));
    chk("midrst_ready", VW'(rdy[0]), VW'(1));
    chk("midrst_a3", tap[0][3], '0);
    chk("midrst_a0", tap[0][0], '0);
    @(negedge clk);
    #2 rst = 1'b0;
    send(rep(16'h7FFF));
    repeat (2) @(negedge clk);
    chk("post_rst_a3", tap[0][3], rep(16'h7FFF));
    chk("post_rst_a2", tap[0][2], '0);
    chk("post_rst_a0", tap[0][0], '0);

    // signed extremes pass through bit-exact
    send(alt(1'b1));
    send(alt(1'b0));
    repeat (2) @(negedge clk);
    chk("signed_a2", tap[0][2], alt(1'b1));
    chk("signed_a3", tap[0][3], alt(1'b0));
    chk("signed_a1", tap[0][1], rep(16'h7FFF));

    // random traffic with occasional resets
    repeat (400) begin
      @(negedge clk);
      in_v      = 1'($urandom_range(0, 1));
      packed_in = rnd();
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    in_v = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
